param_timer_ctrl: RTL and testbench

Controller that sequences a cascaded multi-stage binary counter as a programmable timer. It accepts a terminal count over a valid/ready handshake and runs the counter under start/stop/clear control. At terminal count it wraps the counter and raises a one-cycle expiry pulse, in one-shot or periodic mode. It sits between a register/config master and the counter datapath, and is the only agent that enables or clears the counter.

---
 rtl/param_timer_ctrl_pkg.sv | 26 ++
 rtl/param_timer_ctrl_if.sv | 30 +++
 rtl/param_timer_ctrl_counter.sv | 52 +++++
 rtl/param_timer_ctrl.sv | 123 ++++++++++++
 tb/tb_param_timer_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/param_timer_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_timer_pkg: shared types and constants for the programmable timer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package param_timer_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_STAGE    = 8;
  localparam int EXPIRE_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // States in which a new configuration may be accepted
  function automatic logic is_cfg_state(input state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/param_timer_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_timer_ctrl_if: configuration valid/ready handshake               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface param_timer_ctrl_if import param_timer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_limit;
  logic             cfg_periodic;

  modport master (
    output cfg_valid,
    output cfg_limit,
    output cfg_periodic,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_limit,
    input  cfg_periodic,
    output cfg_ready
  );

endinterface
`default_nettype wire

// File: rtl/param_timer_ctrl_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_counter_en: cascaded multi-stage counter, sync enable and clear |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module param_counter_en import param_timer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGE = DEF_STAGE
) (
  input  wire logic       clk,
  input  wire logic       rst_,
  input  wire logic       en,
  input  wire logic       clr,
  output wire [WIDTH-1:0] q
);

  localparam int NSTG = WIDTH / STAGE;

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    logic [STAGE-1:0] stg_q;
    logic [STAGE-1:0] stg_d;
    logic             inc;

    // Each stage sees the whole lower word, not just its neighbour's carry
    if (k == 0) begin : g_lsb
      assign inc = en;
    end else begin : g_upper
      assign inc = en & (&q[k*STAGE-1:0]);
    end

    always_comb begin
      stg_d = stg_q;
      if (clr) begin
        stg_d = '0;
      end else if (inc) begin
        stg_d = stg_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
        stg_q <= '0;
      end else begin
        stg_q <= stg_d;
      end
    end

    assign q[k*STAGE +: STAGE] = stg_q;
  end

endmodule
`default_nettype wire

// File: rtl/param_timer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_timer_ctrl: programmable one-shot/periodic timer controller     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module param_timer_ctrl import param_timer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGE = DEF_STAGE
) (
  input  wire logic                    clk,
  input  wire logic                    rst_,
  param_timer_ctrl_if.slave            cfg,
  input  wire logic                    start,
  input  wire logic                    stop,
  input  wire logic                    clear,
  output logic [WIDTH-1:0]             q,
  output logic                         expire,
  output logic [EXPIRE_CNT_W-1:0]      expire_cnt,
  output logic                         busy
);

  state_t                  state_q,    state_d;
  logic [WIDTH-1:0]        limit_q,    limit_d;
  logic                    periodic_q, periodic_d;
  logic                    expire_q,   expire_d;
  logic [EXPIRE_CNT_W-1:0] ecnt_q,     ecnt_d;
  logic                    ready_q,    ready_d;
  logic                    busy_q,     busy_d;
  logic                    cnt_en;
  logic                    cnt_clr;
  logic                    accept;
  logic                    go;

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    expire_d   = 1'b0;
    ecnt_d     = ecnt_q;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    accept     = cfg.cfg_valid && ready_q;
    go         = start && !stop;

    if (clear) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else if (accept) begin
      limit_d    = cfg.cfg_limit;
      periodic_d = cfg.cfg_periodic;
      ecnt_d     = '0;
      cnt_clr    = 1'b1;
      state_d    = ARMED;
    end else begin
      case (state_q)
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (q == limit_q) begin
            // Terminal count is inclusive: wrap instead of incrementing
            cnt_clr  = 1'b1;
            expire_d = 1'b1;
            if (ecnt_q != '1) begin
              ecnt_d = ecnt_q + 1'b1;
            end
            if (!periodic_q) begin
              state_d = DONE;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        ARMED, PAUSE, DONE: begin
          if (go) begin
            state_d = RUN;
          end
        end
        default: ;
      endcase
    end

    ready_d = is_cfg_state(state_d);
    busy_d  = (state_d == RUN) || (state_d == PAUSE);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      expire_q   <= 1'b0;
      ecnt_q     <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      expire_q   <= expire_d;
      ecnt_q     <= ecnt_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  param_counter_en #(
    .WIDTH (WIDTH),
    .STAGE (STAGE)
  ) u_cnt (
    .clk  (clk),
    .rst_ (rst_),
    .en   (cnt_en),
    .clr  (cnt_clr),
    .q    (q)
  );

  assign cfg.cfg_ready = ready_q;
  assign expire        = expire_q;
  assign expire_cnt    = ecnt_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_param_timer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_param_timer_ctrl: vector table, directed corners, random vs model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_param_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst_;
  logic        start, stop, clear;
  wire  [31:0] q;
  wire         expire;
  wire  [7:0]  expire_cnt;
  wire         busy;

  param_timer_ctrl_if #(.WIDTH(32)) cfg_if ();

  param_timer_ctrl #(.WIDTH(32), .STAGE(8)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .cfg        (cfg_if),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .q          (q),
    .expire     (expire),
    .expire_cnt (expire_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: timer progress is tracked as a count of run edges,
  // the visible count and expiry fall out of modular arithmetic.
  localparam int S_IDLE = 0, S_ARMED = 1, S_RUN = 2, S_PAUSE = 3, S_DONE = 4;
  int     m_st;
  longint m_runs;
  longint m_lim;
  bit     m_per;
  int     m_ecnt;
  bit     m_exp;

  task automatic model_reset();
    m_st = S_IDLE; m_runs = 0; m_lim = 0; m_per = 0; m_ecnt = 0; m_exp = 0;
  endtask

  task automatic model_edge();
    bit acc;
    acc   = cfg_if.cfg_valid && (m_st == S_IDLE || m_st == S_DONE);
    m_exp = 0;
    if (clear) begin
      m_st = S_IDLE; m_runs = 0;
    end else if (acc) begin
      m_lim = longint'(cfg_if.cfg_limit); m_per = cfg_if.cfg_periodic;
      m_runs = 0; m_ecnt = 0; m_st = S_ARMED;
    end else if (m_st == S_RUN) begin
      if (stop) m_st = S_PAUSE;
      else begin
        m_runs++;
        if (m_runs % (m_lim + 1) == 0) begin
          m_exp  = 1;
          m_ecnt = (m_ecnt >= 255) ? 255 : m_ecnt + 1;
          if (!m_per) m_st = S_DONE;
        end
      end
    end else if (m_st != S_IDLE && start && !stop) begin
      m_st = S_RUN;
    end
  endtask

  task automatic compare_all();
    chk("q",          64'(q),               64'(m_runs % (m_lim + 1)));
    chk("expire",     64'(expire),          64'(m_exp));
    chk("expire_cnt", 64'(expire_cnt),      64'(m_ecnt));
    chk("cfg_ready",  64'(cfg_if.cfg_ready), 64'(m_st == S_IDLE || m_st == S_DONE));
    chk("busy",       64'(busy),            64'(m_st == S_RUN || m_st == S_PAUSE));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    cfg_if.cfg_valid = 0; cfg_if.cfg_limit = '0; cfg_if.cfg_periodic = 0;
    start = 0; stop = 0; clear = 0;
  endtask

  task automatic configure(input logic [31:0] lim, input bit per);
    idle_inputs(); clear = 1; step();
    idle_inputs(); cfg_if.cfg_valid = 1; cfg_if.cfg_limit = lim; cfg_if.cfg_periodic = per; step();
    idle_inputs(); start = 1; step();
    idle_inputs();
  endtask

  typedef struct {
    bit          v;
    logic [31:0] lim;
    bit          per, st, sp, cl;
    logic [31:0] eq;
    bit          ee;
    logic [7:0]  ec;
    bit          er, eb;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int n_exp;
    int first_exp;
    //            v  lim per st sp cl   q  exp cnt rdy busy
    tbl[0]  = '{1, 5, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1};
    tbl[2]  = '{0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 0, 0,   3, 0, 0, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 0,   5, 0, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0};
    tbl[9]  = '{1, 2, 1, 0, 0, 0,   0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 1, 1, 0,   1, 0, 0, 0, 1};
    tbl[13] = '{1, 7, 0, 0, 0, 0,   1, 0, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 1, 0, 0,   1, 0, 0, 0, 1};
    tbl[15] = '{1, 7, 0, 0, 0, 0,   2, 0, 0, 0, 1};
    tbl[16] = '{0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 1};
    tbl[17] = '{0, 0, 0, 1, 0, 1,   0, 0, 1, 1, 0};

    idle_inputs();
    rst_ = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst_ = 1;
    compare_all();

    // Directed table: one-shot limit 5, then pause/ignore/clear corners
    for (int i = 0; i < 18; i++) begin
      cfg_if.cfg_valid = tbl[i].v; cfg_if.cfg_limit = tbl[i].lim;
      cfg_if.cfg_periodic = tbl[i].per;
      start = tbl[i].st; stop = tbl[i].sp; clear = tbl[i].cl;
      step();
      chk($sformatf("tbl%0d.q", i),      64'(q),                64'(tbl[i].eq));
      chk($sformatf("tbl%0d.expire", i), 64'(expire),           64'(tbl[i].ee));
      chk($sformatf("tbl%0d.ecnt", i),   64'(expire_cnt),       64'(tbl[i].ec));
      chk($sformatf("tbl%0d.ready", i),  64'(cfg_if.cfg_ready), 64'(tbl[i].er));
      chk($sformatf("tbl%0d.busy", i),   64'(busy),             64'(tbl[i].eb));
    end
    idle_inputs();

    // Periodic limit=2 for 20 edges: pulses at edges 3,6,...,18
    configure(32'd2, 1);
    n_exp = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("per2.busy", 64'(busy), 64'd1);
      if (expire) n_exp++;
      chk("per2.expire_at", 64'(expire), 64'(i % 3 == 0));
    end
    chk("per2.n_exp", 64'(n_exp), 64'd6);
    chk("per2.ecnt",  64'(expire_cnt), 64'd6);

    // Pause: periodic limit=3, stop at q=2 for 4 edges, expiry moves 4 -> 9
    configure(32'd3, 1);
    step(); step();
    chk("pause.q_before", 64'(q), 64'd2);
    stop = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pause.q_held", 64'(q), 64'd2);
    end
    stop = 0; start = 1; step(); start = 0;
    chk("pause.q_resume", 64'(q), 64'd2);
    first_exp = -1;
    for (int i = 8; i < 30 && first_exp < 0; i++) begin
      step();
      if (expire) first_exp = i;
    end
    chk("pause.expire_edge", 64'(first_exp), 64'd9);

    // Stage 0/1 carry: limit 0x1FF one-shot
    configure(32'h1FF, 0);
    repeat (256) step();
    chk("carry.q256", 64'(q), 64'h100);
    repeat (255) step();
    chk("carry.q511", 64'(q), 64'h1FF);
    chk("carry.noexp", 64'(expire), 64'd0);
    step();
    chk("carry.expire512", 64'(expire), 64'd1);
    chk("carry.done_ready", 64'(cfg_if.cfg_ready), 64'd1);

    // limit=0 periodic: every edge expires, count saturates
    configure(32'd0, 1);
    for (int i = 0; i < 300; i++) begin
      step();
      chk("lim0.expire", 64'(expire), 64'd1);
    end
    chk("lim0.sat", 64'(expire_cnt), 64'd255);

    // Async reset between edges, mid-run
    @(posedge clk);
    #3 rst_ = 0;
    #1;
    model_reset();
    chk("arst.q",      64'(q),                64'd0);
    chk("arst.expire", 64'(expire),           64'd0);
    chk("arst.ecnt",   64'(expire_cnt),       64'd0);
    chk("arst.ready",  64'(cfg_if.cfg_ready), 64'd1);
    chk("arst.busy",   64'(busy),             64'd0);
    @(posedge clk);
    #3 rst_ = 1;

    // Random traffic checked against the model
    for (int i = 0; i < 3000; i++) begin
      cfg_if.cfg_valid    = ($urandom % 100) < 15;
      cfg_if.cfg_limit    = 32'($urandom_range(6, 0));
      cfg_if.cfg_periodic = $urandom % 2;
      start = !cfg_if.cfg_valid && (($urandom % 100) < 35);
      stop  = ($urandom % 100) < 10;
      clear = ($urandom % 100) < 3;
      step();
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
